// File: rtl/cpu_pkg.sv
// Shared types and constants for the program loader and its neighbours
// (instruction memory writer side and fetch start handshake).
package cpu_pkg;

    localparam int INSTR_WIDTH = 16;
    localparam int BYTE_WIDTH  = 8;

    // Loader FSM states. The HDR_* states walk the 4-byte header, DAT_H/DAT_L
    // collect one instruction word, WR commits it, LAUNCH drives start to fetch.
    typedef enum logic [3:0] {
        HDR_AH,
        HDR_AL,
        HDR_CH,
        HDR_CL,
        DAT_H,
        DAT_L,
        WR,
        LAUNCH,
        DONE
    } ldr_state_t;

    // States in which the loader takes a byte from the stream.
    function automatic logic state_accepts_bytes(input ldr_state_t s);
        return (s == HDR_AH) || (s == HDR_AL) || (s == HDR_CH) ||
               (s == HDR_CL) || (s == DAT_H)  || (s == DAT_L);
    endfunction

    // The loader counts as busy once a header has started and until it finishes.
    function automatic logic state_is_busy(input ldr_state_t s);
        return (s != HDR_AH) && (s != DONE);
    endfunction

endpackage

// File: rtl/program_loader_pulse_stretch.sv
// Turns a one-cycle trigger into a level held high for exactly CYCLES clocks.
// CYCLES must lie in 1..15; the counter is 4 bits wide.
module pulse_stretch #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic trig_i,
    output logic pulse_o,
    output logic last_o
);

    localparam logic [3:0] LOAD = 4'(CYCLES - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       pulse_q;
    logic       pulse_d;

    // Next-state: a trigger (re)loads the count, otherwise count down to zero and drop.
    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        if (trig_i) begin
            pulse_d = 1'b1;
            cnt_d   = LOAD;
        end else if (pulse_q) begin
            if (cnt_q == 4'd0) begin
                pulse_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    // State registers; async reset drops the pulse immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;
    // High during the final cycle of the pulse so the owner can move on in step.
    assign last_o  = pulse_q && (cnt_q == 4'd0);

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: parses a big-endian header (start address,
// word count), writes the following 16-bit words into instruction memory
// and then pulses start to the fetch unit with the loaded start address.
//
// Handshake: a byte moves on a rising edge where valid_i and ready_o are both
// high; ready_o depends only on the current state, never on valid_i, and
// byte_i/valid_i are ignored whenever ready_o is low.
module program_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int START_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BYTE_WIDTH-1:0]  byte_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   rearm_i,
    output logic                   imem_we_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    output logic [INSTR_WIDTH-1:0] imem_data_o,
    output logic                   start_o,
    output logic [ADDR_WIDTH-1:0]  start_address_o,
    output logic                   busy_o,
    output logic                   done_o
);

    ldr_state_t             state_q;
    logic [BYTE_WIDTH-1:0]  hi_q;          // first byte of the current 16-bit field
    logic [ADDR_WIDTH-1:0]  addr_q;        // next instruction-memory address
    logic [15:0]            remain_q;      // words still to be written
    logic                   imem_we_q;
    logic [ADDR_WIDTH-1:0]  imem_addr_q;
    logic [INSTR_WIDTH-1:0] imem_data_q;
    logic [ADDR_WIDTH-1:0]  start_addr_q;

    logic                   accept;
    logic [15:0]            rx_field;
    logic                   launch_trig;
    logic                   start_pulse;
    logic                   start_last;

    assign ready_o  = state_accepts_bytes(state_q);
    assign accept   = valid_i && ready_o;
    // Completed big-endian field: stored high byte plus the byte on the bus now.
    assign rx_field = {hi_q, byte_i};

    // LAUNCH is entered either from an empty header or from the final write.
    assign launch_trig = ((state_q == HDR_CL) && accept && (rx_field == 16'd0)) ||
                         ((state_q == WR) && (remain_q == 16'd1));

    pulse_stretch #(
        .CYCLES (START_CYCLES)
    ) u_start_pulse (
        .clk     (clk),
        .rst     (rst),
        .trig_i  (launch_trig),
        .pulse_o (start_pulse),
        .last_o  (start_last)
    );

    // Loader FSM with its datapath registers and registered memory-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HDR_AH;
            hi_q         <= '0;
            addr_q       <= '0;
            remain_q     <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_data_q  <= '0;
            start_addr_q <= '0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                HDR_AH: begin
                    if (accept) begin
                        hi_q    <= byte_i;
                        state_q <= HDR_AL;
                    end
                end
                HDR_AL: begin
                    if (accept) begin
                        // Header address is 16 bits; narrower PCs keep the low bits.
                        addr_q       <= ADDR_WIDTH'(rx_field);
                        start_addr_q <= ADDR_WIDTH'(rx_field);
                        state_q      <= HDR_CH;
                    end
                end
                HDR_CH: begin
                    if (accept) begin
                        hi_q    <= byte_i;
                        state_q <= HDR_CL;
                    end
                end
                HDR_CL: begin
                    if (accept) begin
                        remain_q <= rx_field;
                        state_q  <= (rx_field == 16'd0) ? LAUNCH : DAT_H;
                    end
                end
                DAT_H: begin
                    if (accept) begin
                        hi_q    <= byte_i;
                        state_q <= DAT_L;
                    end
                end
                DAT_L: begin
                    if (accept) begin
                        // Present the write one cycle after the low byte lands.
                        imem_we_q   <= 1'b1;
                        imem_addr_q <= addr_q;
                        imem_data_q <= rx_field;
                        state_q     <= WR;
                    end
                end
                WR: begin
                    // Address wraps silently at the top of the address space.
                    addr_q   <= addr_q + 1'b1;
                    remain_q <= remain_q - 16'd1;
                    state_q  <= (remain_q == 16'd1) ? LAUNCH : DAT_H;
                end
                LAUNCH: begin
                    if (start_last) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (rearm_i) begin
                        state_q <= HDR_AH;
                    end
                end
                default: begin
                    state_q <= HDR_AH;
                end
            endcase
        end
    end

    assign imem_we_o       = imem_we_q;
    assign imem_addr_o     = imem_addr_q;
    assign imem_data_o     = imem_data_q;
    assign start_o         = start_pulse;
    assign start_address_o = start_addr_q;
    assign busy_o          = state_is_busy(state_q);
    assign done_o          = (state_q == DONE);

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: reset checks, a table of directed images,
// hand-written reset corner cases and randomized images against a model.
module tb_program_loader;

    localparam int AW = 16;
    localparam int SC = 2;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    byte_i = 8'h00;
    logic          valid_i = 1'b0;
    logic          rearm_i = 1'b0;
    logic          ready_o;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [15:0]   imem_data_o;
    logic          start_o;
    logic [AW-1:0] start_address_o;
    logic          busy_o;
    logic          done_o;

    always #5 clk = ~clk;

    program_loader #(
        .ADDR_WIDTH   (AW),
        .START_CYCLES (SC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .byte_i          (byte_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .rearm_i         (rearm_i),
        .imem_we_o       (imem_we_o),
        .imem_addr_o     (imem_addr_o),
        .imem_data_o     (imem_data_o),
        .start_o         (start_o),
        .start_address_o (start_address_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];          // {addr, data} of each expected write, in order
    logic [15:0] exp_start = 16'h0;
    int          start_cnt = 0;
    logic        prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write and start monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we_o) begin
                check("we_single_cycle", {31'b0, prev_we}, 32'd0);
                check("ready_low_in_wr", {31'b0, ready_o}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                             imem_addr_o, imem_data_o);
                end else begin
                    check("write", {imem_addr_o, imem_data_o}, exp_q.pop_front());
                end
            end
            if (start_o) begin
                start_cnt++;
                check("start_address_at_launch", {16'b0, start_address_o}, {16'b0, exp_start});
                check("ready_low_in_launch", {31'b0, ready_o}, 32'd0);
            end
            prev_we = imem_we_o;
        end else begin
            prev_we = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        int waited;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        valid_i = 1'b0;
        repeat (g) begin
            @(posedge clk); #1;
        end
        byte_i  = b;
        valid_i = 1'b1;
        waited  = 0;
        while (!ready_o && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!ready_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got ready_o 0 expected 1 within 50 cycles");
        end else begin
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
    endtask

    task automatic drive_image(input logic [15:0] addr, input logic [15:0] words[$], input int gap_max);
        logic [15:0] n;
        n = 16'(words.size());
        send_byte(addr[15:8], gap_max);
        send_byte(addr[7:0], gap_max);
        send_byte(n[15:8], gap_max);
        send_byte(n[7:0], gap_max);
        foreach (words[i]) begin
            send_byte(words[i][15:8], gap_max);
            send_byte(words[i][7:0], gap_max);
            check("write_latency", {31'b0, imem_we_o}, 32'd1);
        end
    endtask

    // Wait for DONE, check launch results, prove DONE ignores bytes, then rearm.
    task automatic finish_image(input logic [15:0] addr);
        int k;
        k = 0;
        while (!done_o && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_reached", {31'b0, done_o}, 32'd1);
        check("writes_drained", exp_q.size(), 32'd0);
        check("start_cycles", start_cnt, SC);
        check("start_address_held", {16'b0, start_address_o}, {16'b0, addr});
        check("busy_in_done", {31'b0, busy_o}, 32'd0);
        check("ready_in_done", {31'b0, ready_o}, 32'd0);
        byte_i  = 8'h5A;
        valid_i = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        check("done_sticky_without_rearm", {31'b0, done_o}, 32'd1);
        check("start_low_in_done", {31'b0, start_o}, 32'd0);
        rearm_i = 1'b1;
        @(posedge clk); #1;
        rearm_i = 1'b0;
        check("ready_after_rearm", {31'b0, ready_o}, 32'd1);
        check("done_after_rearm", {31'b0, done_o}, 32'd0);
        exp_q.delete();
        start_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'b0, ready_o}, 32'd1);
        check({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
        check({tag, "_done"}, {31'b0, done_o}, 32'd0);
        check({tag, "_we"}, {31'b0, imem_we_o}, 32'd0);
        check({tag, "_start"}, {31'b0, start_o}, 32'd0);
        check({tag, "_imem_addr"}, {16'b0, imem_addr_o}, 32'd0);
        check({tag, "_imem_data"}, {16'b0, imem_data_o}, 32'd0);
        check({tag, "_start_address"}, {16'b0, start_address_o}, 32'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [15:0] addr;
        int          n;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] a0;   // expected address of first write
        logic [15:0] a1;   // expected address of second write
        int          gap;
    } vec_t;

    vec_t vecs[5];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [15:0] words[$];
        logic [15:0] ra;
        int          rn;
        int          k;

        vecs[0] = '{16'h000A, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0};
        vecs[1] = '{16'h0005, 2, 16'h1234, 16'hABCD, 16'h0005, 16'h0006, 0};
        vecs[2] = '{16'h0005, 2, 16'h1234, 16'hABCD, 16'h0005, 16'h0006, 3};
        vecs[3] = '{16'hFFFF, 2, 16'h1111, 16'h2222, 16'hFFFF, 16'h0000, 0};
        vecs[4] = '{16'h0000, 1, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 0};

        // Reset state, while held and after release.
        #1;
        check_reset_outputs("reset_held");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset_released");

        // Reset in the middle of a stream abandons the image.
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        check("busy_mid_stream", {31'b0, busy_o}, 32'd1);
        check("ready_mid_stream", {31'b0, ready_o}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_stream");
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed images; the zero-count one right after the abandoned load.
        for (int v = 0; v < 5; v++) begin
            words.delete();
            exp_q.delete();
            exp_start = vecs[v].addr;
            start_cnt = 0;
            if (vecs[v].n > 0) begin
                words.push_back(vecs[v].w0);
                exp_q.push_back({vecs[v].a0, vecs[v].w0});
            end
            if (vecs[v].n > 1) begin
                words.push_back(vecs[v].w1);
                exp_q.push_back({vecs[v].a1, vecs[v].w1});
            end
            drive_image(vecs[v].addr, words, vecs[v].gap);
            finish_image(vecs[v].addr);
        end

        // Asynchronous reset during LAUNCH cuts start immediately.
        words.delete();
        exp_start = 16'h0042;
        start_cnt = 0;
        drive_image(16'h0042, words, 0);
        k = 0;
        while (!start_o && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("start_seen_before_reset", {31'b0, start_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_in_launch");
        @(posedge clk); #1;
        rst = 1'b0;
        start_cnt = 0;
        exp_q.delete();

        // Randomized images against the address/data model.
        for (int r = 0; r < 20; r++) begin
            words.delete();
            exp_q.delete();
            if ($urandom_range(3, 0) == 0) ra = 16'hFFFF - 16'($urandom_range(3, 0));
            else ra = 16'($urandom);
            rn = int'($urandom_range(5, 0));
            for (int i = 0; i < rn; i++) begin
                words.push_back(16'($urandom));
                exp_q.push_back({ra + 16'(i), words[i]});
            end
            exp_start = ra;
            start_cnt = 0;
            drive_image(ra, words, int'($urandom_range(3, 0)));
            finish_image(ra);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
